truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, giving the number of DUT inputs swept (legal range 1..16).
REQ-002 The block SHALL have parameter HOLD, default 2, giving the cycles each vector is held (legal range 1..255).
REQ-003 The block SHALL have parameter CHECK_OP, default 0, selecting the expected function: 0 = AND-reduce, 1 = OR-reduce, 2 = XOR-reduce.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous reset, active high.
REQ-007 start  input  1  request to begin a sweep; sampled in IDLE only.
REQ-008 mode  input  1  vector order, 0 = binary count, 1 = Gray code; latched at start acceptance.
REQ-009 dutOut  input  1  response of the combinational DUT under test.
REQ-010 dutIn  output  N_IN  vector driven to the DUT.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 errCount  output  N_IN+1  number of mismatching vectors in the last or current sweep.
REQ-014 errFlag  output  1  high when errCount is non-zero.
REQ-015 firstErrVec  output  N_IN  dutIn value of the first mismatch in the sweep; 0 if none.

Function
REQ-016 The FSM SHALL have the states IDLE, DRIVE and DONE.
REQ-017 In IDLE, start=1 SHALL cause a transition to DRIVE on the next edge, with the following effects:
- index = 0 and hold counter = 0;
- the mode value is latched;
- errCount, errFlag and firstErrVec are cleared.
REQ-018 In IDLE, dutIn SHALL be 0 and busy SHALL be 0.
REQ-019 In DRIVE, dutIn SHALL equal the index in binary mode, or index ^ (index >> 1) in Gray mode, and SHALL be registered.
REQ-020 In DRIVE, busy SHALL be 1.
REQ-021 Each vector SHALL be held for exactly HOLD cycles; the hold counter runs from 0 to HOLD-1.
REQ-022 dutOut SHALL be compared only in the cycle where hold counter = HOLD-1.
- The expected value is the CHECK_OP reduction of the current dutIn.
REQ-023 On a mismatch, errCount SHALL increment by 1.
- If errCount was 0 before the increment, firstErrVec is loaded with the current dutIn.
REQ-024 errCount SHALL never wrap, since it can reach at most 2^N_IN.
REQ-025 After the compare cycle:
- if index = 2^N_IN - 1, the FSM goes to DONE;
- otherwise, index increments and the hold counter returns to 0.
REQ-026 A full sweep SHALL take 2^N_IN * HOLD DRIVE cycles.
REQ-027 DONE SHALL last exactly one cycle, with done=1, busy=0 and dutIn=0, then return to IDLE.
REQ-028 errCount, errFlag and firstErrVec SHALL hold their values after DONE until the next accepted start or reset.
REQ-029 start SHALL be ignored in DRIVE and DONE; a start held high through DONE is accepted in the following IDLE cycle.
REQ-030 A change on mode during DRIVE SHALL have no effect on the sweep in progress.
REQ-031 CHECK_OP values outside 0..2 SHALL behave as 0.

Reset
REQ-032 rst=1 SHALL force all of the following at the next edge, overriding any other event in the same cycle including start:
- state = IDLE;
- dutIn, busy, done, errCount, errFlag, firstErrVec, index and hold counter = 0.
REQ-033 Reset asserted mid-sweep SHALL abandon the sweep.
- No done pulse is generated.
- The next accepted start sweeps from index 0.

Verification
REQ-034 Scenario 1: N_IN=4, HOLD=2, CHECK_OP=0, ideal 4-input AND DUT, start pulse.
- busy is high for 32 cycles.
- done pulses once.
- errCount = 0 and errFlag = 0.
REQ-035 Scenario 2: same setup, DUT output stuck at 0.
- errCount = 1.
- firstErrVec = 4'hF.
- errFlag = 1.
REQ-036 Scenario 3: mode=1, HOLD=1.
- dutIn sequence = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8.
- done follows in the cycle after the vector 8 is driven.
REQ-037 Scenario 4: CHECK_OP=2, DUT output stuck at 0.
- errCount = 8.
- firstErrVec = 4'h1.
REQ-038 Scenario 5: assert rst while dutIn = 5 mid-sweep.
- All outputs are 0 and no done pulse occurs.
- A new start restarts the sweep with dutIn = 0.
REQ-039 Scenario 6: pulse start while busy = 1.
- The pulse is ignored and the sweep length is unchanged.
- Holding start through DONE begins a second sweep, and errCount is cleared.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus generator and checker for a small combinational DUT.
// Walks every input vector in binary or Gray order and counts response mismatches.
module truth_table_sweeper #(
    parameter int N_IN     = 4,
    parameter int HOLD     = 2,
    parameter int CHECK_OP = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic            dutOut,
    output logic [N_IN-1:0] dutIn,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   errCount,
    output logic            errFlag,
    output logic [N_IN-1:0] firstErrVec
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   index_q, index_d;
    logic [7:0]        hold_q, hold_d;
    logic              mode_q, mode_d;
    logic [N_IN-1:0]   dutIn_q, dutIn_d;
    logic [N_IN:0]     errCount_q, errCount_d;
    logic [N_IN-1:0]   firstErr_q, firstErr_d;

    logic              expected;
    logic              lastHold;
    logic              lastIndex;
    logic [N_IN-1:0]   nextIndex;
    logic [N_IN-1:0]   nextVec;

    // Unsupported operator codes fall back to AND-reduce.
    always_comb begin
        case (CHECK_OP)
            1:       expected = |dutIn_q;
            2:       expected = ^dutIn_q;
            default: expected = &dutIn_q;
        endcase
    end

    assign lastHold  = (hold_q == 8'(HOLD - 1));
    assign lastIndex = (index_q == {N_IN{1'b1}});
    assign nextIndex = index_q + 1'b1;
    assign nextVec   = mode_q ? (nextIndex ^ (nextIndex >> 1)) : nextIndex;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        hold_d     = hold_q;
        mode_d     = mode_q;
        dutIn_d    = dutIn_q;
        errCount_d = errCount_q;
        firstErr_d = firstErr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRIVE;
                    index_d    = '0;
                    hold_d     = '0;
                    mode_d     = mode;
                    dutIn_d    = '0;
                    errCount_d = '0;
                    firstErr_d = '0;
                end
            end
            DRIVE: begin
                if (lastHold) begin
                    // errCount tops out at 2^N_IN, which its N_IN+1 bits always hold.
                    if (dutOut != expected) begin
                        errCount_d = errCount_q + 1'b1;
                        if (errCount_q == '0) begin
                            firstErr_d = dutIn_q;
                        end
                    end
                    hold_d = '0;
                    if (lastIndex) begin
                        state_d = DONE;
                        index_d = '0;
                        dutIn_d = '0;
                    end else begin
                        index_d = nextIndex;
                        dutIn_d = nextVec;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            index_q    <= '0;
            hold_q     <= '0;
            mode_q     <= 1'b0;
            dutIn_q    <= '0;
            errCount_q <= '0;
            firstErr_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            hold_q     <= hold_d;
            mode_q     <= mode_d;
            dutIn_q    <= dutIn_d;
            errCount_q <= errCount_d;
            firstErr_q <= firstErr_d;
        end
    end

    assign dutIn       = dutIn_q;
    assign busy        = (state_q == DRIVE);
    assign done        = (state_q == DONE);
    assign errCount    = errCount_q;
    assign errFlag     = |errCount_q;
    assign firstErrVec = firstErr_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: three instances cover AND/HOLD=2,
// XOR/HOLD=1 and OR/HOLD=3, each fed by an ideal or stuck-at-0 DUT model.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       startS [3];
    logic       modeS  [3];
    logic       dutOutS[3];
    logic [3:0] dutInS [3];
    logic       busyS  [3];
    logic       doneS  [3];
    logic [4:0] errCountS [3];
    logic       errFlagS  [3];
    logic [3:0] firstErrS [3];
    int         kind   [3];

    int         checks = 0;
    int         errors = 0;
    logic [3:0] vecQ[$];

    always #5 clk = ~clk;

    // Golden reduction used both for the expected results and the ideal DUT.
    function automatic logic expRed(input int op, input logic [3:0] v);
        case (op)
            1:       return |v;
            2:       return ^v;
            default: return &v;
        endcase
    endfunction

    // kind 0 is an ideal DUT, anything else is a DUT stuck at 0.
    function automatic logic respOf(input int k, input int op, input logic [3:0] v);
        return (k == 0) ? expRed(op, v) : 1'b0;
    endfunction

    function automatic int holdOf(input int w);
        return (w == 0) ? 2 : (w == 1) ? 1 : 3;
    endfunction

    function automatic int opOf(input int w);
        return (w == 0) ? 0 : (w == 1) ? 2 : 1;
    endfunction

    assign dutOutS[0] = respOf(kind[0], 0, dutInS[0]);
    assign dutOutS[1] = respOf(kind[1], 2, dutInS[1]);
    assign dutOutS[2] = respOf(kind[2], 1, dutInS[2]);

    truth_table_sweeper #(.N_IN(4), .HOLD(2), .CHECK_OP(0)) dutA (
        .clk(clk), .rst(rst), .start(startS[0]), .mode(modeS[0]), .dutOut(dutOutS[0]),
        .dutIn(dutInS[0]), .busy(busyS[0]), .done(doneS[0]), .errCount(errCountS[0]),
        .errFlag(errFlagS[0]), .firstErrVec(firstErrS[0])
    );

    truth_table_sweeper #(.N_IN(4), .HOLD(1), .CHECK_OP(2)) dutB (
        .clk(clk), .rst(rst), .start(startS[1]), .mode(modeS[1]), .dutOut(dutOutS[1]),
        .dutIn(dutInS[1]), .busy(busyS[1]), .done(doneS[1]), .errCount(errCountS[1]),
        .errFlag(errFlagS[1]), .firstErrVec(firstErrS[1])
    );

    truth_table_sweeper #(.N_IN(4), .HOLD(3), .CHECK_OP(1)) dutC (
        .clk(clk), .rst(rst), .start(startS[2]), .mode(modeS[2]), .dutOut(dutOutS[2]),
        .dutIn(dutInS[2]), .busy(busyS[2]), .done(doneS[2]), .errCount(errCountS[2]),
        .errFlag(errFlagS[2]), .firstErrVec(firstErrS[2])
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full sweep on instance w. Expected vectors go into the queue as the
    // start is driven and are popped every busy cycle; error totals come from the model.
    task automatic applyStimulus(input int w, input logic m, input int k,
                                 input bit pulseMid, input bit holdEnd);
        int expErr;
        int expFirst;
        int busyCnt;
        int doneCnt;
        int cyc;
        int h;
        logic [3:0] v;
        h        = holdOf(w);
        expErr   = 0;
        expFirst = 0;
        kind[w]  = k;
        vecQ.delete();
        for (int i = 0; i < 16; i++) begin
            v = m ? 4'(i ^ (i >> 1)) : 4'(i);
            for (int j = 0; j < h; j++) vecQ.push_back(v);
            if (respOf(k, opOf(w), v) != expRed(opOf(w), v)) begin
                if (expErr == 0) expFirst = int'(v);
                expErr++;
            end
        end
        startS[w] = 1'b1;
        modeS[w]  = m;
        step();
        startS[w] = 1'b0;
        modeS[w]  = ~m;
        busyCnt = 0;
        doneCnt = 0;
        cyc     = 0;
        while (cyc < 200 && doneCnt == 0) begin
            if (busyS[w]) begin
                busyCnt++;
                if (vecQ.size() == 0) checkOutput("extra busy cycle", 1, 0);
                else checkOutput("dutIn", int'(dutInS[w]), int'(vecQ.pop_front()));
            end
            if (doneS[w]) begin
                doneCnt++;
                checkOutput("dutIn at done", int'(dutInS[w]), 0);
                checkOutput("busy at done", int'(busyS[w]), 0);
                checkOutput("errCount", int'(errCountS[w]), expErr);
                checkOutput("errFlag", int'(errFlagS[w]), (expErr != 0) ? 1 : 0);
                checkOutput("firstErrVec", int'(firstErrS[w]), expFirst);
            end
            startS[w] = (pulseMid && cyc == 7) || (holdEnd && vecQ.size() <= 2);
            step();
            cyc++;
        end
        checkOutput("done pulses", doneCnt, 1);
        checkOutput("busy cycles", busyCnt, 16 * h);
        checkOutput("vectors left", vecQ.size(), 0);
        checkOutput("done one cycle", int'(doneS[w]), 0);
        checkOutput("busy idle", int'(busyS[w]), 0);
        checkOutput("errCount held", int'(errCountS[w]), expErr);
        checkOutput("firstErrVec held", int'(firstErrS[w]), expFirst);
        vecQ.delete();
    endtask

    initial begin
        int cyc;
        int doneSeen;
        rst = 1'b1;
        for (int w = 0; w < 3; w++) begin
            startS[w] = 1'b0;
            modeS[w]  = 1'b0;
            kind[w]   = 0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state.
        checkOutput("reset dutIn", int'(dutInS[0]), 0);
        checkOutput("reset busy", int'(busyS[0]), 0);
        checkOutput("reset done", int'(doneS[0]), 0);
        checkOutput("reset errCount", int'(errCountS[0]), 0);
        checkOutput("reset errFlag", int'(errFlagS[0]), 0);
        checkOutput("reset firstErrVec", int'(firstErrS[0]), 0);

        // Ideal AND, then stuck-at-0 AND.
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1, 1'b0, 1'b0);
        // Gray order with HOLD=1 on the XOR instance, then stuck-at-0 XOR.
        applyStimulus(1, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1, 1'b0, 1'b0);
        // OR instance, Gray order, stuck at 0: fails on every vector but 0.
        applyStimulus(2, 1'b1, 1, 1'b0, 1'b0);

        // Reset mid-sweep at vector 5, with start also high in the reset cycle.
        kind[0]   = 0;
        startS[0] = 1'b1;
        modeS[0]  = 1'b0;
        step();
        startS[0] = 1'b0;
        cyc = 0;
        while (dutInS[0] != 4'd5 && cyc < 100) begin
            step();
            cyc++;
        end
        checkOutput("reached vector 5", int'(dutInS[0]), 5);
        rst       = 1'b1;
        startS[0] = 1'b1;
        step();
        rst       = 1'b0;
        startS[0] = 1'b0;
        checkOutput("mid reset dutIn", int'(dutInS[0]), 0);
        checkOutput("mid reset busy", int'(busyS[0]), 0);
        checkOutput("mid reset done", int'(doneS[0]), 0);
        checkOutput("mid reset errCount", int'(errCountS[0]), 0);
        checkOutput("reset clears other errCount", int'(errCountS[2]), 0);
        checkOutput("reset clears other errFlag", int'(errFlagS[2]), 0);
        checkOutput("reset clears other firstErrVec", int'(firstErrS[2]), 0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (doneS[0] || busyS[0]) doneSeen++;
            step();
        end
        checkOutput("no activity after reset", doneSeen, 0);
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);

        // Start pulsed while busy, then held through DONE into a second sweep.
        applyStimulus(0, 1'b0, 1, 1'b1, 1'b1);
        step();
        startS[0] = 1'b0;
        checkOutput("restart busy", int'(busyS[0]), 1);
        checkOutput("restart dutIn", int'(dutInS[0]), 0);
        checkOutput("restart errCount", int'(errCountS[0]), 0);
        checkOutput("restart errFlag", int'(errFlagS[0]), 0);
        checkOutput("restart firstErrVec", int'(firstErrS[0]), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checkOutput("final busy", int'(busyS[0]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
